regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: the ALU pipe (source A) and the load/memory pipe (source B). Each source pushes {address, data, ppp} through a valid/ready handshake into its own FIFO. A round-robin arbiter grants one FIFO head per cycle and drives registered write-port signals (enable, address, data, ppp) into the register file. The block sits between the execute/memory stages and the register file write port.

Parameters:
FIFO_DEPTH, 2, entries per source FIFO; power of 2, minimum 2
ADDR_W, 5, register address width
DATA_W, 64, writeback data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
a_valid  in  1  source A write request
a_ready  out  1  source A FIFO can accept
a_addr  in  ADDR_W  source A destination register
a_data  in  DATA_W  source A write data
a_ppp  in  3  source A participation field
b_valid  in  1  source B write request
b_ready  out  1  source B FIFO can accept
b_addr  in  ADDR_W  source B destination register
b_data  in  DATA_W  source B write data
b_ppp  in  3  source B participation field
wb_en  out  1  register file write enable
wb_addr  out  ADDR_W  register file write address
wb_data  out  DATA_W  register file write data
wb_ppp  out  3  register file participation field
busy  out  1  either FIFO non-empty, or wb_en high
err_ppp  out  1  sticky illegal-ppp flag (see Optional Feature)

Behaviour:
- Reset, on the clk edge with reset high:
  - both FIFOs are emptied;
  - wb_en, wb_addr, wb_data, wb_ppp, err_ppp and busy all go to 0;
  - the round-robin pointer is set to "last = B", so A wins the first tie.
- a_ready and b_ready are forced to 0 while reset is high.
- Handshake:
  - x_ready = !reset && (FIFO count != FIFO_DEPTH). It depends only on registered state, never on x_valid.
  - A push occurs when x_valid && x_ready at a clk edge.
  - Signals presented while x_ready=0 are ignored. The source must hold them until a push occurs.
- Arbitration, evaluated each cycle on FIFO heads:
  - If neither FIFO is non-empty, there is no grant.
  - If exactly one is non-empty, that FIFO is granted.
  - If both are non-empty, the source not granted last is granted. The pointer updates only on a grant.
- Grant: pops that head and registers it onto wb_addr/wb_data/wb_ppp with wb_en=1 for exactly one cycle.
  - When no grant occurs, wb_en=0 and wb_addr/wb_data/wb_ppp hold their previous values.
- Latency:
  - Push at edge k → entry at head after edge k → earliest wb_en=1 in the cycle after edge k+1.
  - Minimum latency is 2 cycles. There is no bypass of an empty FIFO.
- Throughput: 1 write per cycle total. Under continuous contention the grants alternate strictly A, B, A, B.
- Simultaneous push and pop on the same FIFO are both performed. The count is unchanged.
  - When the FIFO is full, ready=0 that cycle even if a pop occurs (no full bypass).
- Ordering:
  - Per-source order is preserved.
  - Cross-source order equals grant order.
  - Same-address writes from A and B resolve in grant order. The last granted write wins.
- Address 0 is forwarded unchanged; the register file ignores it.
- FIFO pointers wrap modulo FIFO_DEPTH. The count has width clog2(FIFO_DEPTH)+1.
- Reset mid-operation: all queued entries are discarded, with no wb_en in the cycle after the reset edge. Ready returns 1 in the first cycle with reset low.
- ppp values 000–100 pass through unmodified.

Optional Feature:
Macro WB_PPP_CHECK_EN.
- Defined:
  - A granted entry with ppp in 101–111 is popped and consumes the grant (the pointer updates).
  - wb_en stays 0 that cycle, and wb_addr/wb_data/wb_ppp hold.
  - err_ppp sets to 1 and stays 1 until reset.
- Undefined: every granted entry is forwarded unchanged, including illegal ppp, and err_ppp is tied to 0.

Test Plan:
1. After reset, push A {addr=3, data=0x1111_2222_3333_4444, ppp=000} at edge k → wb_en=1 for exactly the one cycle after edge k+1, with wb_addr=3 and wb_data=0x1111_2222_3333_4444; busy=0 thereafter.
2. Push A {addr=1, ppp=001} and B {addr=2, ppp=010} on the same edge, first contention after reset → wb sequence is addr=1 then addr=2 on consecutive cycles.
3. Both sources push every cycle with incrementing data, 8 entries each → wb alternates A,B,A,B; a_ready/b_ready drop once the FIFOs are full; all 16 entries appear with no loss or duplication, in order per source.
4. Queue 2 A + 1 B entries, then assert reset for 1 cycle → wb_en=0 afterward; a_ready=b_ready=0 during reset and 1 in the first cycle after; busy=0.
5. A full FIFO with simultaneous grant and a_valid=1 → no push that cycle (a_ready=0); push accepted next cycle; count is correct.
6. Push A ppp=101, addr=5:
   - with WB_PPP_CHECK_EN → no wb_en pulse, err_ppp=1 sticky; the next B entry is granted normally;
   - without the macro → wb_en=1 with wb_ppp=101, and err_ppp stays 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (A) and load (B) writeback pipes.
// Define WB_PPP_CHECK_EN to drop granted entries with illegal ppp and raise the sticky err_ppp flag.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic [2:0]        a_ppp,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic [2:0]        b_ppp,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        wb_ppp,
  output logic              busy,
  output logic              err_ppp
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PPP_W = 3;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PPP_W-1:0]  ppp;
  } wb_entry_t;

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  // Per-source FIFO storage and bookkeeping
  wb_entry_t        fifo_a_q [FIFO_DEPTH];
  wb_entry_t        fifo_b_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_a_q, wr_a_d, rd_a_q, rd_a_d;
  logic [PTR_W-1:0] wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  last_e     last_q, last_d;
  logic      wb_en_q, wb_en_d;
  wb_entry_t wb_q, wb_d;

  wb_entry_t in_a, in_b, head_a, head_b, head_sel;
  logic      push_a, push_b, grant_a, grant_b, grant_any;
  logic      nonempty_a, nonempty_b;

  assign in_a = {a_addr, a_data, a_ppp};
  assign in_b = {b_addr, b_data, b_ppp};

  // Ready looks only at registered occupancy, so a full FIFO stays closed even on a pop cycle
  assign a_ready = !reset && (cnt_a_q != CNT_FULL);
  assign b_ready = !reset && (cnt_b_q != CNT_FULL);
  assign push_a  = a_valid && a_ready;
  assign push_b  = b_valid && b_ready;

  assign nonempty_a = (cnt_a_q != CNT_ZERO);
  assign nonempty_b = (cnt_b_q != CNT_ZERO);
  assign head_a     = fifo_a_q[rd_a_q];
  assign head_b     = fifo_b_q[rd_b_q];

  // Round-robin: on a tie the source not granted last wins
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (nonempty_a && (!nonempty_b || last_q == LAST_B)) begin
      grant_a = 1'b1;
    end else if (nonempty_b) begin
      grant_b = 1'b1;
    end
  end

  assign grant_any = grant_a || grant_b;
  assign head_sel  = grant_b ? head_b : head_a;

  always_comb begin
    wr_a_d  = wr_a_q;
    rd_a_d  = rd_a_q;
    cnt_a_d = cnt_a_q;
    wr_b_d  = wr_b_q;
    rd_b_d  = rd_b_q;
    cnt_b_d = cnt_b_q;
    last_d  = last_q;

    if (push_a) wr_a_d = wr_a_q + PTR_ONE;
    if (grant_a) rd_a_d = rd_a_q + PTR_ONE;
    case ({push_a, grant_a})
      2'b10:   cnt_a_d = cnt_a_q + CNT_W'(1);
      2'b01:   cnt_a_d = cnt_a_q - CNT_W'(1);
      default: cnt_a_d = cnt_a_q;
    endcase

    if (push_b) wr_b_d = wr_b_q + PTR_ONE;
    if (grant_b) rd_b_d = rd_b_q + PTR_ONE;
    case ({push_b, grant_b})
      2'b10:   cnt_b_d = cnt_b_q + CNT_W'(1);
      2'b01:   cnt_b_d = cnt_b_q - CNT_W'(1);
      default: cnt_b_d = cnt_b_q;
    endcase

    if (grant_a) begin
      last_d = LAST_A;
    end else if (grant_b) begin
      last_d = LAST_B;
    end
  end

`ifdef WB_PPP_CHECK_EN
  localparam logic [PPP_W-1:0] PPP_MAX = PPP_W'(4);

  logic err_q, err_d;

  // Illegal ppp still consumes its grant but never reaches the register file
  always_comb begin
    wb_en_d = 1'b0;
    wb_d    = wb_q;
    err_d   = err_q;
    if (grant_any) begin
      if (head_sel.ppp > PPP_MAX) begin
        err_d = 1'b1;
      end else begin
        wb_en_d = 1'b1;
        wb_d    = head_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_ppp = err_q;
`else
  always_comb begin
    wb_en_d = 1'b0;
    wb_d    = wb_q;
    if (grant_any) begin
      wb_en_d = 1'b1;
      wb_d    = head_sel;
    end
  end

  assign err_ppp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_a_q  <= '0;
      rd_a_q  <= '0;
      cnt_a_q <= '0;
      wr_b_q  <= '0;
      rd_b_q  <= '0;
      cnt_b_q <= '0;
      last_q  <= LAST_B;
      wb_en_q <= 1'b0;
      wb_q    <= '0;
    end else begin
      wr_a_q  <= wr_a_d;
      rd_a_q  <= rd_a_d;
      cnt_a_q <= cnt_a_d;
      wr_b_q  <= wr_b_d;
      rd_b_q  <= rd_b_d;
      cnt_b_q <= cnt_b_d;
      last_q  <= last_d;
      wb_en_q <= wb_en_d;
      wb_q    <= wb_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the counters
  always_ff @(posedge clk) begin
    if (push_a) fifo_a_q[wr_a_q] <= in_a;
    if (push_b) fifo_b_q[wr_b_q] <= in_b;
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_q.addr;
  assign wb_data = wb_q.data;
  assign wb_ppp  = wb_q.ppp;
  assign busy    = nonempty_a || nonempty_b || wb_en_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts every write-port cycle.
module tb_regfile_wb_arbiter;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  logic              clk, reset;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr, wb_addr;
  logic [DATA_W-1:0] a_data, b_data, wb_data;
  logic [2:0]        a_ppp, b_ppp, wb_ppp;
  logic              wb_en, busy, err_ppp;

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_ppp(a_ppp),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_ppp(b_ppp),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ppp(wb_ppp),
    .busy(busy), .err_ppp(err_ppp)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        ppp;
    bit                src;
  } ent_t;

  typedef struct {
    bit                src;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        ppp;
    int                cyc;
  } log_t;

  ent_t mq_a[$], mq_b[$], exp_q[$];
  log_t wlog[$];
  bit   m_last_b = 1'b1;
  bit   m_err    = 1'b0;
  logic [127:0] m_hold = '0;
  bit   saw_a_full, saw_b_full;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: arbitrate on pre-edge contents, then accept pushes
  initial forever begin
    ent_t e;
    bit ra, rb, ga, gb;
    @(posedge clk);
    if (reset) begin
      mq_a.delete(); mq_b.delete(); exp_q.delete();
      m_last_b = 1'b1; m_err = 1'b0; m_hold = '0;
    end else begin
      ra = mq_a.size() < DEPTH;
      rb = mq_b.size() < DEPTH;
      ga = (mq_a.size() != 0) && ((mq_b.size() == 0) || m_last_b);
      gb = !ga && (mq_b.size() != 0);
      if (ga || gb) begin
        if (ga) begin e = mq_a.pop_front(); m_last_b = 1'b0; end
        else    begin e = mq_b.pop_front(); m_last_b = 1'b1; end
`ifdef WB_PPP_CHECK_EN
        if (e.ppp > 3'd4) m_err = 1'b1;
        else exp_q.push_back(e);
`else
        exp_q.push_back(e);
`endif
      end
      if (a_valid && ra) mq_a.push_back('{addr: a_addr, data: a_data, ppp: a_ppp, src: 1'b0});
      if (b_valid && rb) mq_b.push_back('{addr: b_addr, data: b_data, ppp: b_ppp, src: 1'b1});
    end
  end

  // Scoreboard: compare every cycle's write-port state on the falling edge
  initial forever begin
    ent_t e;
    bit exp_en;
    logic [127:0] obs;
    @(negedge clk);
    exp_en = (exp_q.size() != 0);
    obs = 128'({wb_addr, wb_data, wb_ppp});
    check_eq("wb_en", 128'(wb_en), 128'(exp_en));
    if (exp_en) begin
      e = exp_q.pop_front();
      m_hold = 128'({e.addr, e.data, e.ppp});
      if (wb_en === 1'b1) begin
        check_eq("wb_payload", obs, m_hold);
        wlog.push_back('{src: e.src, addr: wb_addr, ppp: wb_ppp, cyc: cyc});
      end
    end else if (wb_en !== 1'b1) begin
      check_eq("wb_hold", obs, m_hold);
    end
    check_eq("a_ready", 128'(a_ready), 128'(!reset && mq_a.size() < DEPTH));
    check_eq("b_ready", 128'(b_ready), 128'(!reset && mq_b.size() < DEPTH));
    check_eq("busy", 128'(busy), 128'(mq_a.size() != 0 || mq_b.size() != 0 || exp_en));
    check_eq("err_ppp", 128'(err_ppp), 128'(m_err));
    if (!reset && !a_ready) saw_a_full = 1'b1;
    if (!reset && !b_ready) saw_b_full = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    wlog.delete();
    saw_a_full = 1'b0; saw_b_full = 1'b0;
  endtask

  task automatic push_a(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d,
                        input logic [2:0] p, output int acc_cyc);
    int waited = 0;
    a_valid = 1'b1; a_addr = ad; a_data = d; a_ppp = p;
    @(negedge clk);
    while (!a_ready && waited < 100) begin @(negedge clk); waited++; end
    if (!a_ready) check_eq("push_a_timeout", 128'(a_ready), 128'(1));
    tick();
    acc_cyc = cyc;
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d,
                        input logic [2:0] p, output int acc_cyc);
    int waited = 0;
    b_valid = 1'b1; b_addr = ad; b_data = d; b_ppp = p;
    @(negedge clk);
    while (!b_ready && waited < 100) begin @(negedge clk); waited++; end
    if (!b_ready) check_eq("push_b_timeout", 128'(b_ready), 128'(1));
    tick();
    acc_cyc = cyc;
    b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ka, kb, na;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; a_data = '0; a_ppp = '0; b_addr = '0; b_data = '0; b_ppp = '0;

    // Reset state
    @(posedge clk); @(negedge clk);
    check_eq("rst_wb_en", 128'(wb_en), 128'(0));
    check_eq("rst_wb_addr", 128'(wb_addr), 128'(0));
    check_eq("rst_wb_data", 128'(wb_data), 128'(0));
    check_eq("rst_wb_ppp", 128'(wb_ppp), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_a_ready", 128'(a_ready), 128'(0));
    check_eq("rst_b_ready", 128'(b_ready), 128'(0));
    do_reset(1);

    // 1: single write, two-cycle latency
    push_a(5'd3, 64'h1111_2222_3333_4444, 3'b000, ka);
    wait_cycles(4);
    check_eq("t1_count", 128'(wlog.size()), 128'(1));
    if (wlog.size() >= 1) begin
      check_eq("t1_latency", 128'(wlog[0].cyc), 128'(ka + 1));
      check_eq("t1_addr", 128'(wlog[0].addr), 128'(3));
    end
    check_eq("t1_busy_idle", 128'(busy), 128'(0));

    // 2: first contention after reset goes to A
    do_reset(2);
    fork
      push_a(5'd1, 64'h0000_0000_0000_00A1, 3'b001, ka);
      push_b(5'd2, 64'h0000_0000_0000_00B2, 3'b010, kb);
    join
    wait_cycles(4);
    check_eq("t2_count", 128'(wlog.size()), 128'(2));
    if (wlog.size() >= 2) begin
      check_eq("t2_first_addr", 128'(wlog[0].addr), 128'(1));
      check_eq("t2_second_addr", 128'(wlog[1].addr), 128'(2));
      check_eq("t2_back_to_back", 128'(wlog[1].cyc), 128'(wlog[0].cyc + 1));
    end

    // 3: continuous contention, 8 entries per source
    do_reset(1);
    fork
      for (int i = 0; i < 8; i++) push_a(5'(i), 64'hA000_0000_0000_0000 | 64'(i), 3'(i % 5), ka);
      for (int i = 0; i < 8; i++) push_b(5'(i), 64'hB000_0000_0000_0000 | 64'(i), 3'(i % 5), kb);
    join
    wait_cycles(6);
    check_eq("t3_count", 128'(wlog.size()), 128'(16));
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      check_eq($sformatf("t3_src_%0d", i), 128'(wlog[i].src), 128'(i % 2));
      check_eq($sformatf("t3_addr_%0d", i), 128'(wlog[i].addr), 128'(i / 2));
    end
    check_eq("t3_a_full_seen", 128'(saw_a_full), 128'(1));
    check_eq("t3_b_full_seen", 128'(saw_b_full), 128'(1));
    check_eq("t3_busy_idle", 128'(busy), 128'(0));

    // 4: reset with entries queued discards them
    do_reset(1);
    fork
      push_a(5'd7, 64'h4A1, 3'b000, ka);
      push_b(5'd8, 64'h4B1, 3'b000, kb);
    join
    push_a(5'd9, 64'h4A2, 3'b000, ka);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t4_a_ready_in_rst", 128'(a_ready), 128'(0));
    check_eq("t4_b_ready_in_rst", 128'(b_ready), 128'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("t4_wb_en_after", 128'(wb_en), 128'(0));
    check_eq("t4_a_ready_after", 128'(a_ready), 128'(1));
    check_eq("t4_b_ready_after", 128'(b_ready), 128'(1));
    check_eq("t4_busy_after", 128'(busy), 128'(0));
    wait_cycles(4);
    check_eq("t4_count", 128'(wlog.size()), 128'(1));

    // 5: full FIFO granted while a_valid is held
    do_reset(1);
    a_valid = 1'b1; a_addr = 5'd11; a_data = 64'h51; a_ppp = 3'b000;
    b_valid = 1'b1; b_addr = 5'd21; b_data = 64'h61; b_ppp = 3'b000;
    tick();
    a_addr = 5'd12; a_data = 64'h52; b_addr = 5'd22; b_data = 64'h62;
    tick();
    a_addr = 5'd13; a_data = 64'h53; b_valid = 1'b0;
    tick();
    a_addr = 5'd14; a_data = 64'h54;
    @(negedge clk);
    check_eq("t5_full_ready", 128'(a_ready), 128'(0));
    tick();
    @(negedge clk);
    check_eq("t5_ready_back", 128'(a_ready), 128'(1));
    tick();
    a_valid = 1'b0;
    wait_cycles(6);
    na = 0;
    foreach (wlog[i]) if (wlog[i].src == 1'b0) na++;
    check_eq("t5_a_count", 128'(na), 128'(4));
    check_eq("t5_total", 128'(wlog.size()), 128'(6));
    check_eq("t5_busy_idle", 128'(busy), 128'(0));

    // 6: illegal ppp from A, then a normal B entry
    do_reset(1);
    push_a(5'd5, 64'h6A, 3'b101, ka);
    push_b(5'd6, 64'h6B, 3'b011, kb);
    wait_cycles(4);
`ifdef WB_PPP_CHECK_EN
    check_eq("t6_count", 128'(wlog.size()), 128'(1));
    if (wlog.size() >= 1) check_eq("t6_b_addr", 128'(wlog[0].addr), 128'(6));
    check_eq("t6_err_set", 128'(err_ppp), 128'(1));
    wait_cycles(3);
    check_eq("t6_err_sticky", 128'(err_ppp), 128'(1));
    do_reset(1);
    check_eq("t6_err_cleared", 128'(err_ppp), 128'(0));
`else
    check_eq("t6_count", 128'(wlog.size()), 128'(2));
    if (wlog.size() >= 1) begin
      check_eq("t6_a_addr", 128'(wlog[0].addr), 128'(5));
      check_eq("t6_a_ppp", 128'(wlog[0].ppp), 128'(3'b101));
    end
    check_eq("t6_err_low", 128'(err_ppp), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
